// File: rtl/simd_issue_throttle.sv
// simd_issue_throttle: issue gate between the warp index stage and the SIMD ALUs.
// It passes instructions through combinationally and enforces a global in-flight
// limit and a per-warp in-flight limit. It retires up to N_COMMIT commits per cycle.
// It signals block completion once the last instruction has issued and drained.
// Ports:
//   i_clk, i_rst                        clock, asynchronous active-high reset
//   src_rdy/src_ack                     upstream handshake
//   i_pc, i_warpid, i_payload, i_islast instruction fields
//   inst_rdy/inst_ack                   issue handshake to the ALU
//   o_pc, o_warpid, o_payload           combinational copies of the instruction fields
//   i_commit_dval, i_commit_warpid      per-port commit strobes and warp ids
//   fin_rdy/fin_ack                     block-complete handshake
//   o_busy, o_n_pending, o_underflow    status: per-warp busy, global count, sticky underflow
module simd_issue_throttle #(
    parameter int N_INST = 16,
    parameter int MAX_WARP = 8,
    parameter int PBW = 64,
    parameter int N_PENDING = 4,
    parameter int N_PENDING_WARP = 2,
    parameter int N_COMMIT = 2,
    localparam int INST_BW = $clog2(N_INST + 1),
    localparam int WID_BW = $clog2(MAX_WARP),
    localparam int GBW = $clog2(N_PENDING + 1),
    localparam int PWBW = $clog2(N_PENDING_WARP + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       src_rdy,
    output logic                       src_ack,
    input  logic [INST_BW-1:0]         i_pc,
    input  logic [WID_BW-1:0]          i_warpid,
    input  logic [PBW-1:0]             i_payload,
    input  logic                       i_islast,
    output logic                       inst_rdy,
    input  logic                       inst_ack,
    output logic [INST_BW-1:0]         o_pc,
    output logic [WID_BW-1:0]          o_warpid,
    output logic [PBW-1:0]             o_payload,
    input  logic [N_COMMIT-1:0]        i_commit_dval,
    input  logic [N_COMMIT*WID_BW-1:0] i_commit_warpid,
    output logic                       fin_rdy,
    input  logic                       fin_ack,
    output logic [MAX_WARP-1:0]        o_busy,
    output logic [GBW-1:0]             o_n_pending,
    output logic                       o_underflow
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
    state_e state_q, state_d;
    logic [GBW-1:0] gcnt_q, gcnt_d;
    logic [PWBW-1:0] wcnt_q [MAX_WARP];
    logic [PWBW-1:0] wcnt_d [MAX_WARP];
    logic underflow_q, underflow_d;
    logic blocked, issue;

    assign o_pc = i_pc;
    assign o_warpid = i_warpid;
    assign o_payload = i_payload;
    assign fin_rdy = state_q == DONE;
    assign o_n_pending = gcnt_q;
    assign o_underflow = underflow_q;

    // Only registered counts gate issue, so a commit frees credit one cycle later.
    always_comb begin
        blocked = (int'(gcnt_q) == N_PENDING) || (int'(wcnt_q[i_warpid]) == N_PENDING_WARP);
        inst_rdy = (state_q == RUN) && src_rdy && !blocked;
        src_ack = inst_rdy && inst_ack;
        issue = src_ack;
    end

    // Each warp nets its same-cycle issue against the commits naming it.
    // A count that would go negative clamps at 0 and flags underflow.
    always_comb begin : counters
        int dec, avail, g;
        underflow_d = underflow_q;
        g = int'(gcnt_q) + int'(issue);
        for (int p = 0; p < N_COMMIT; p++)
            g -= int'(i_commit_dval[p]);
        for (int w = 0; w < MAX_WARP; w++) begin
            dec = 0;
            for (int p = 0; p < N_COMMIT; p++)
                dec += int'(i_commit_dval[p] && i_commit_warpid[p*WID_BW +: WID_BW] == WID_BW'(w));
            avail = int'(wcnt_q[w]) + int'(issue && i_warpid == WID_BW'(w));
            underflow_d |= dec > avail;
            wcnt_d[w] = dec > avail ? '0 : PWBW'(avail - dec);
        end
        underflow_d |= g < 0;
        gcnt_d = g < 0 ? '0 : GBW'(g);
    end

    // Using the next-state count lets an islast issue that drains in the same cycle go straight to DONE.
    always_comb begin
        state_d = (state_q == RUN && issue && i_islast) ? (gcnt_d == '0 ? DONE : DRAIN)
                : (state_q == DRAIN && gcnt_d == '0) ? DONE
                : (state_q == DONE && fin_ack) ? RUN
                : state_q;
    end

    always_comb begin
        o_busy = '0;
        for (int w = 0; w < MAX_WARP; w++)
            o_busy[w] = wcnt_q[w] != '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RUN;
            gcnt_q <= '0;
            underflow_q <= 1'b0;
            for (int w = 0; w < MAX_WARP; w++)
                wcnt_q[w] <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q <= gcnt_d;
            underflow_q <= underflow_d;
            for (int w = 0; w < MAX_WARP; w++)
                wcnt_q[w] <= wcnt_d[w];
        end
    end
endmodule

// File: tb/tb_simd_issue_throttle.sv
// tb_simd_issue_throttle: directed scoreboard bench for simd_issue_throttle.
module tb_simd_issue_throttle;
    localparam int N_INST = 16, MAX_WARP = 8, PBW = 64, N_PENDING = 4, N_PENDING_WARP = 2, N_COMMIT = 2;
    localparam int INST_BW = $clog2(N_INST + 1), WID_BW = $clog2(MAX_WARP);
    localparam int GBW = $clog2(N_PENDING + 1);

    logic i_clk = 1'b0, i_rst = 1'b1;
    logic src_rdy, src_ack, i_islast, inst_rdy, inst_ack, fin_rdy, fin_ack, o_underflow;
    logic [INST_BW-1:0] i_pc, o_pc;
    logic [WID_BW-1:0] i_warpid, o_warpid;
    logic [PBW-1:0] i_payload, o_payload;
    logic [N_COMMIT-1:0] i_commit_dval;
    logic [N_COMMIT*WID_BW-1:0] i_commit_warpid;
    logic [MAX_WARP-1:0] o_busy;
    logic [GBW-1:0] o_n_pending;

    typedef struct {
        logic [INST_BW-1:0] pc;
        logic [WID_BW-1:0] wid;
        logic [PBW-1:0] pl;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_m;
    int total = 0, errs = 0;

    simd_issue_throttle #(
        .N_INST(N_INST), .MAX_WARP(MAX_WARP), .PBW(PBW),
        .N_PENDING(N_PENDING), .N_PENDING_WARP(N_PENDING_WARP), .N_COMMIT(N_COMMIT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack),
        .i_pc(i_pc), .i_warpid(i_warpid), .i_payload(i_payload), .i_islast(i_islast),
        .inst_rdy(inst_rdy), .inst_ack(inst_ack), .o_pc(o_pc), .o_warpid(o_warpid),
        .o_payload(o_payload), .i_commit_dval(i_commit_dval), .i_commit_warpid(i_commit_warpid),
        .fin_rdy(fin_rdy), .fin_ack(fin_ack), .o_busy(o_busy), .o_n_pending(o_n_pending),
        .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [PBW-1:0] pay(input int pc);
        return 64'hC0DE_0000_0000_0000 ^ (64'(pc) * 64'h0101_0101);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues are sampled mid-cycle and checked against the oldest expected instruction.
    always @(negedge i_clk) begin
        if (!i_rst && inst_rdy && inst_ack) begin
            if (exp_q.size() == 0) chk("unexpected_issue", 64'(o_pc), 64'(0) - 64'(1));
            else begin
                e_m = exp_q.pop_front();
                chk("issue_pc", 64'(o_pc), 64'(e_m.pc));
                chk("issue_wid", 64'(o_warpid), 64'(e_m.wid));
                chk("issue_payload", o_payload, e_m.pl);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int pc, input int wid, input bit last);
        src_rdy = 1'b1;
        i_pc = INST_BW'(pc);
        i_warpid = WID_BW'(wid);
        i_payload = pay(pc);
        i_islast = last;
    endtask

    task automatic issue(input int pc, input int wid, input bit last);
        drive(pc, wid, last);
        #1 chk("issue_rdy", 64'(inst_rdy), 64'(1));
        exp_q.push_back('{INST_BW'(pc), WID_BW'(wid), pay(pc)});
        step();
        src_rdy = 1'b0;
        i_islast = 1'b0;
    endtask

    task automatic commit(input int n, input int w0, input int w1);
        i_commit_dval = N_COMMIT'(n == 2 ? 3 : n);
        i_commit_warpid = {WID_BW'(w1), WID_BW'(w0)};
    endtask

    task automatic commit_step(input int n, input int w0, input int w1);
        commit(n, w0, w1);
        step();
        i_commit_dval = '0;
    endtask

    initial begin
        src_rdy = 1'b1; inst_ack = 1'b0; i_pc = 3; i_warpid = '0; i_payload = pay(3); i_islast = 1'b0;
        i_commit_dval = '0; i_commit_warpid = '0; fin_ack = 1'b0;
        #2;
        chk("rst_inst_rdy", 64'(inst_rdy), 64'(1));
        chk("rst_src_ack", 64'(src_ack), 64'(0));
        chk("rst_fin_rdy", 64'(fin_rdy), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_npend", 64'(o_n_pending), 64'(0));
        chk("rst_underflow", 64'(o_underflow), 64'(0));
        chk("pass_pc", 64'(o_pc), 64'(3));
        chk("pass_payload", o_payload, pay(3));
        step(); step();
        i_rst = 1'b0; src_rdy = 1'b0; inst_ack = 1'b1;
        step();
        // global limit
        for (int k = 0; k < 4; k++) issue(k, k, 1'b0);
        chk("g_npend4", 64'(o_n_pending), 64'(4));
        drive(4, 4, 1'b0);
        #1 chk("g_blocked", 64'(inst_rdy), 64'(0));
        chk("g_src_ack", 64'(src_ack), 64'(0));
        commit(1, 2, 0);
        #1 chk("g_commit_cycle_rdy", 64'(inst_rdy), 64'(0));
        step();
        i_commit_dval = '0;
        chk("g_npend3", 64'(o_n_pending), 64'(3));
        chk("g_src_ack_next", 64'(src_ack), 64'(1));
        issue(4, 4, 1'b0);
        chk("g_npend_refill", 64'(o_n_pending), 64'(4));
        chk("g_busy", 64'(o_busy), 64'h1B);
        commit_step(2, 0, 1);
        commit_step(2, 3, 4);
        chk("g_drained", 64'(o_n_pending), 64'(0));
        // per-warp limit
        issue(5, 5, 1'b0);
        issue(6, 5, 1'b0);
        drive(7, 5, 1'b0);
        #1 chk("w_blocked", 64'(inst_rdy), 64'(0));
        chk("w_busy", 64'(o_busy), 64'h20);
        issue(8, 1, 1'b0);
        chk("w_busy2", 64'(o_busy), 64'h22);
        drive(7, 5, 1'b0);
        commit(1, 5, 0);
        #1 chk("w_commit_cycle_rdy", 64'(inst_rdy), 64'(0));
        step();
        i_commit_dval = '0;
        issue(7, 5, 1'b0);
        chk("w_npend", 64'(o_n_pending), 64'(3));
        commit_step(2, 5, 5);
        chk("w_dual_busy", 64'(o_busy), 64'h02);
        chk("w_dual_npend", 64'(o_n_pending), 64'(1));
        chk("w_dual_uf", 64'(o_underflow), 64'(0));
        commit_step(1, 1, 0);
        // dual commit on warp 3
        issue(9, 3, 1'b0);
        issue(10, 3, 1'b0);
        chk("d_npend", 64'(o_n_pending), 64'(2));
        chk("d_busy", 64'(o_busy), 64'h08);
        commit_step(2, 3, 3);
        chk("d_busy_clr", 64'(o_busy), 64'(0));
        chk("d_npend_clr", 64'(o_n_pending), 64'(0));
        chk("d_uf", 64'(o_underflow), 64'(0));
        // completion
        issue(11, 0, 1'b0);
        issue(12, 1, 1'b1);
        drive(13, 2, 1'b0);
        #1 chk("c_drain_rdy", 64'(inst_rdy), 64'(0));
        chk("c_drain_ack", 64'(src_ack), 64'(0));
        chk("c_npend", 64'(o_n_pending), 64'(2));
        commit_step(1, 0, 0);
        chk("c_fin_early", 64'(fin_rdy), 64'(0));
        commit(1, 1, 0);
        #1 chk("c_fin_same_cycle", 64'(fin_rdy), 64'(0));
        step();
        i_commit_dval = '0;
        chk("c_fin", 64'(fin_rdy), 64'(1));
        chk("c_done_rdy", 64'(inst_rdy), 64'(0));
        chk("c_done_npend", 64'(o_n_pending), 64'(0));
        fin_ack = 1'b1;
        step();
        fin_ack = 1'b0;
        chk("c_fin_clr", 64'(fin_rdy), 64'(0));
        issue(13, 2, 1'b0);
        chk("c_next_block", 64'(o_n_pending), 64'(1));
        commit_step(1, 2, 0);
        // underflow
        commit_step(1, 7, 0);
        chk("u_flag", 64'(o_underflow), 64'(1));
        chk("u_busy", 64'(o_busy), 64'(0));
        chk("u_npend", 64'(o_n_pending), 64'(0));
        step();
        chk("u_sticky", 64'(o_underflow), 64'(1));
        // reset in DRAIN
        issue(14, 0, 1'b0);
        issue(15, 1, 1'b1);
        chk("r_npend", 64'(o_n_pending), 64'(2));
        chk("r_drain_rdy", 64'(inst_rdy), 64'(0));
        i_rst = 1'b1;
        #1 chk("r_npend_clr", 64'(o_n_pending), 64'(0));
        chk("r_busy_clr", 64'(o_busy), 64'(0));
        chk("r_uf_clr", 64'(o_underflow), 64'(0));
        chk("r_fin_clr", 64'(fin_rdy), 64'(0));
        drive(16, 0, 1'b0);
        #1 chk("r_run", 64'(inst_rdy), 64'(1));
        src_rdy = 1'b0;
        step();
        i_rst = 1'b0;
        issue(16, 0, 1'b0);
        chk("r_restart", 64'(o_n_pending), 64'(1));
        commit_step(1, 1, 0);
        chk("r_stale_uf", 64'(o_underflow), 64'(1));
        chk("r_stale_busy", 64'(o_busy), 64'h01);
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", total - errs, total);
        $finish;
    end
endmodule
